// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
// Consumes one unsigned weighted sum per timestep, leaks the membrane
// potential by vmem >> LEAK_SHIFT on every accepted timestep, fires a
// one-cycle spike when the potential reaches THRESH, and reports the spike
// count after a window of TIMESTEPS accepted sums.
module lif_neuron #(
    parameter int SUM_WIDTH  = 19,
    parameter int VMEM_WIDTH = 24,
    parameter int THRESH     = 1000,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    parameter int TIMESTEPS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sum_valid,
    input  logic [SUM_WIDTH-1:0]  sum_in,
    output logic                  spike_out,
    output logic [VMEM_WIDTH-1:0] vmem_out,
    output logic [7:0]            spike_count,
    output logic                  busy,
    output logic                  done
);

    localparam int TS_W  = $clog2(TIMESTEPS + 1);
    localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    localparam logic [VMEM_WIDTH:0] THRESH_W = (VMEM_WIDTH + 1)'(THRESH);
    localparam logic [TS_W-1:0]     TS_LAST  = TS_W'(TIMESTEPS - 1);
    localparam logic [REF_W-1:0]    REF_INIT = REF_W'(REFRAC);

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        REFRACTORY
    } state_t;

    state_t state, state_nx;

    logic [VMEM_WIDTH-1:0] vmem, vmem_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [TS_W-1:0]       ts_cnt, ts_nx;
    logic [REF_W-1:0]      ref_cnt, ref_nx;
    logic                  spike_nx, done_nx;

    logic [VMEM_WIDTH:0]   vsum;
    logic [VMEM_WIDTH-1:0] vnext;
    logic                  fire;
    logic                  accept;
    logic                  last;

    assign vmem_out    = vmem;
    assign spike_count = cnt;

    // Leak, integrate and saturate; decide whether this timestep fires.
    always_comb begin
        vsum   = {1'b0, vmem - (vmem >> LEAK_SHIFT)}
               + {{(VMEM_WIDTH + 1 - SUM_WIDTH){1'b0}}, sum_in};
        vnext  = vsum[VMEM_WIDTH] ? '1 : vsum[VMEM_WIDTH-1:0];
        fire   = ({1'b0, vnext} >= THRESH_W);
        // start wins over a coincident sample; IDLE never accepts samples
        accept = sum_valid && !start && (state != IDLE);
        last   = (ts_cnt == TS_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: window end has priority over spike/refractory moves.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = INTEGRATE;
        end else if (accept) begin
            if (last) begin
                state_nx = IDLE;
            end else if (state == INTEGRATE) begin
                if (fire && (REFRAC > 0)) begin
                    state_nx = REFRACTORY;
                end
            end else if (ref_cnt <= REF_W'(1)) begin
                state_nx = INTEGRATE;
            end
        end
    end

    // State-derived outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Next values of the datapath registers.
    always_comb begin
        vmem_nx  = vmem;
        cnt_nx   = cnt;
        ts_nx    = ts_cnt;
        ref_nx   = ref_cnt;
        spike_nx = 1'b0;
        done_nx  = 1'b0;
        if (start) begin
            vmem_nx = '0;
            cnt_nx  = '0;
            ts_nx   = '0;
            ref_nx  = '0;
        end else if (accept) begin
            ts_nx   = ts_cnt + TS_W'(1);
            done_nx = last;
            if (state == INTEGRATE) begin
                if (fire) begin
                    spike_nx = 1'b1;
                    vmem_nx  = '0;
                    cnt_nx   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    ref_nx   = REF_INIT;
                end else begin
                    vmem_nx = vnext;
                end
            end else begin
                // refractory timestep: sample dropped, potential pinned at 0
                vmem_nx = '0;
                if (ref_cnt != '0) begin
                    ref_nx = ref_cnt - REF_W'(1);
                end
            end
        end
    end

    // Datapath registers; spike_out and done are registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vmem      <= '0;
            cnt       <= '0;
            ts_cnt    <= '0;
            ref_cnt   <= '0;
            spike_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            vmem      <= vmem_nx;
            cnt       <= cnt_nx;
            ts_cnt    <= ts_nx;
            ref_cnt   <= ref_nx;
            spike_out <= spike_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron: default instance plus a saturation
// instance (THRESH = 2^24-1, LEAK_SHIFT = 23) sharing the same stimulus.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sum_valid;
    logic [18:0] sum_in;

    logic        spike_out, busy, done;
    logic [23:0] vmem_out;
    logic [7:0]  spike_count;

    logic        s_spike, s_busy, s_done;
    logic [23:0] s_vmem;
    logic [7:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk(clk), .rst(rst), .start(start), .sum_valid(sum_valid),
        .sum_in(sum_in), .spike_out(spike_out), .vmem_out(vmem_out),
        .spike_count(spike_count), .busy(busy), .done(done)
    );

    lif_neuron #(
        .THRESH(16777215), .LEAK_SHIFT(23), .TIMESTEPS(64)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .sum_valid(sum_valid),
        .sum_in(sum_in), .spike_out(s_spike), .vmem_out(s_vmem),
        .spike_count(s_count), .busy(s_busy), .done(s_done)
    );

    // advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; sum_valid = 1'b0; sum_in = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_sum(input logic [18:0] v);
        sum_valid = 1'b1; sum_in = v;
        tick();
        sum_valid = 1'b0; sum_in = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sum_valid = 1'b0; sum_in = '0;
        tick(); tick();
        checks++;
        if ({spike_out, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {spike_out, busy, done});
        end
        checks++;
        if (vmem_out !== 24'd0 || spike_count !== 8'd0) begin
            errors++; $display("FAIL reset_values vmem %0d cnt %0d want 0 0", vmem_out, spike_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_defaults();
        do_start();
        checks++;
        if (busy !== 1'b1 || vmem_out !== 24'd0) begin
            errors++; $display("FAIL def_start busy %b vmem %0d want 1 0", busy, vmem_out);
        end
        do_sum(19'd500);
        checks++;
        if (vmem_out !== 24'd500 || spike_out !== 1'b0) begin
            errors++; $display("FAIL def_sum1 vmem %0d spike %b want 500 0", vmem_out, spike_out);
        end
        do_sum(19'd500);
        checks++;
        if (vmem_out !== 24'd969 || spike_out !== 1'b0) begin
            errors++; $display("FAIL def_sum2 vmem %0d spike %b want 969 0", vmem_out, spike_out);
        end
        do_sum(19'd500);
        checks++;
        if (spike_out !== 1'b1 || vmem_out !== 24'd0 || spike_count !== 8'd1) begin
            errors++; $display("FAIL def_fire spike %b vmem %0d cnt %0d want 1 0 1", spike_out, vmem_out, spike_count);
        end
        tick();
        checks++;
        if (spike_out !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL def_pulse spike %b busy %b want 0 1", spike_out, busy);
        end
    endtask

    task automatic test_refractory();
        do_start();
        do_sum(19'd1000);
        checks++;
        if (spike_out !== 1'b1 || spike_count !== 8'd1) begin
            errors++; $display("FAIL ref_fire1 spike %b cnt %0d want 1 1", spike_out, spike_count);
        end
        do_sum(19'd5000);
        checks++;
        if (spike_out !== 1'b0 || vmem_out !== 24'd0) begin
            errors++; $display("FAIL ref_skip1 spike %b vmem %0d want 0 0", spike_out, vmem_out);
        end
        do_sum(19'd5000);
        checks++;
        if (spike_out !== 1'b0 || vmem_out !== 24'd0) begin
            errors++; $display("FAIL ref_skip2 spike %b vmem %0d want 0 0", spike_out, vmem_out);
        end
        do_sum(19'd1000);
        checks++;
        if (spike_out !== 1'b1 || spike_count !== 8'd2) begin
            errors++; $display("FAIL ref_fire2 spike %b cnt %0d want 1 2", spike_out, spike_count);
        end
    endtask

    task automatic test_window_end();
        do_start();
        for (int i = 0; i < 8; i++) begin
            do_sum(19'd0);
            if (i < 7) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL win_early%0d done %b busy %b want 0 1", i, done, busy);
                end
            end
            tick();
        end
        // re-check the cycle right after the 8th sample: rewind by sampling a fresh window
        do_start();
        for (int i = 0; i < 7; i++) begin
            do_sum(19'd0);
            tick();
        end
        do_sum(19'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || spike_count !== 8'd0) begin
            errors++; $display("FAIL win_done done %b busy %b cnt %0d want 1 0 0", done, busy, spike_count);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL win_done_pulse done %b want 0", done);
        end
        do_sum(19'd5000);
        checks++;
        if (vmem_out !== 24'd0 || spike_out !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL win_ninth vmem %0d spike %b busy %b want 0 0 0", vmem_out, spike_out, busy);
        end
    endtask

    task automatic test_coincident();
        do_start();
        for (int i = 0; i < 7; i++) begin
            do_sum(19'd0);
        end
        do_sum(19'd1200);
        checks++;
        if (spike_out !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL coinc_pulses spike %b done %b want 1 1", spike_out, done);
        end
        checks++;
        if (spike_count !== 8'd1 || busy !== 1'b0 || vmem_out !== 24'd0) begin
            errors++; $display("FAIL coinc_state cnt %0d busy %b vmem %0d want 1 0 0", spike_count, busy, vmem_out);
        end
        tick();
        checks++;
        if (spike_count !== 8'd1 || spike_out !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL coinc_hold cnt %0d spike %b done %b want 1 0 0", spike_count, spike_out, done);
        end
    endtask

    task automatic test_restart_reset();
        do_start();
        do_sum(19'd600);
        do_sum(19'd300);
        checks++;
        if (vmem_out !== 24'd863) begin
            errors++; $display("FAIL rst_pre vmem %0d want 863", vmem_out);
        end
        start = 1'b1; sum_valid = 1'b1; sum_in = 19'd900;
        tick();
        start = 1'b0; sum_valid = 1'b0; sum_in = '0;
        checks++;
        if (vmem_out !== 24'd0 || spike_out !== 1'b0 || busy !== 1'b1 || spike_count !== 8'd0) begin
            errors++; $display("FAIL restart vmem %0d spike %b busy %b cnt %0d want 0 0 1 0", vmem_out, spike_out, busy, spike_count);
        end
        do_sum(19'd100);
        checks++;
        if (vmem_out !== 24'd100) begin
            errors++; $display("FAIL restart_first vmem %0d want 100", vmem_out);
        end
        do_sum(19'd1500);
        checks++;
        if (spike_out !== 1'b1 || spike_count !== 8'd1) begin
            errors++; $display("FAIL restart_fire spike %b cnt %0d want 1 1", spike_out, spike_count);
        end
        rst = 1'b1; sum_valid = 1'b1; sum_in = 19'd2000;
        tick();
        rst = 1'b0;
        checks++;
        if (vmem_out !== 24'd0 || spike_count !== 8'd0 || {spike_out, busy, done} !== 3'b000) begin
            errors++; $display("FAIL midrst vmem %0d cnt %0d flags %b want 0 0 000", vmem_out, spike_count, {spike_out, busy, done});
        end
        do_sum(19'd2000);
        checks++;
        if (vmem_out !== 24'd0 || busy !== 1'b0 || spike_out !== 1'b0) begin
            errors++; $display("FAIL idle_ignore vmem %0d busy %b spike %b want 0 0 0", vmem_out, busy, spike_out);
        end
    endtask

    task automatic test_saturation();
        longint m = 0;
        longint u;
        logic [23:0] exp_v;
        logic        exp_f;
        bit          fired = 0;
        do_start();
        for (int i = 0; i < 40 && !fired; i++) begin
            u     = m - (m >> 23) + 524287;
            exp_f = (u >= 64'd16777215);
            exp_v = exp_f ? 24'd0 : 24'(u);
            do_sum(19'd524287);
            checks++;
            if (s_vmem !== exp_v || s_spike !== exp_f) begin
                errors++; $display("FAIL sat_step%0d vmem %0d spike %b want %0d %b", i, s_vmem, s_spike, exp_v, exp_f);
            end
            m     = exp_f ? 0 : u;
            fired = exp_f;
        end
        checks++;
        if (!fired || s_count !== 8'd1) begin
            errors++; $display("FAIL sat_fired model_fired %b cnt %0d want 1 1", fired, s_count);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_refractory();
        test_window_end();
        test_coincident();
        test_restart_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
